// File: rtl/demux3_buf.sv
// demux3_buf: routes one bus value to one of three single-entry holding
// registers (valid/ack handshake each) or drops it into a saturating counter.
module demux3_buf #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_select,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ack,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ack,
   output logic [WIDTH-1:0] out2_data,
   output logic             out2_valid,
   input  logic             out2_ack,
   output logic [CNT_W-1:0] drop_count
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } chan_state_t;

   chan_state_t      state_q [3];
   chan_state_t      state_d [3];
   logic [WIDTH-1:0] data_q  [3];
   logic [2:0]       ack;
   logic [2:0]       load;
   logic             sel_ready;
   logic             accept;
   logic             drop;

   assign ack = {out2_ack, out1_ack, out0_ack};

   // Ready depends only on the addressed channel; a stalled channel never
   // blocks transfers aimed elsewhere.
   always_comb begin
      sel_ready = 1'b1;
      case (in_select)
         2'd0:    sel_ready = (state_q[0] == EMPTY) || out0_ack;
         2'd1:    sel_ready = (state_q[1] == EMPTY) || out1_ack;
         2'd2:    sel_ready = (state_q[2] == EMPTY) || out2_ack;
         default: sel_ready = 1'b1;
      endcase
      in_ready = sel_ready && !reset;
      accept   = in_valid && in_ready;
      drop     = accept && (in_select == 2'd3);
   end

   // Per-channel next state: a load wins over an ack (refill keeps FULL).
   always_comb begin
      load = '0;
      for (int unsigned n = 0; n < 3; n++) begin
         state_d[n] = state_q[n];
         load[n]    = accept && (in_select == 2'(n));
         if (load[n])
            state_d[n] = FULL;
         else if (state_q[n] == FULL && ack[n])
            state_d[n] = EMPTY;
      end
   end

   // Channel state, holding registers and drop counter; reset discards all.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned n = 0; n < 3; n++) begin
            state_q[n] <= EMPTY;
            data_q[n]  <= '0;
         end
         drop_count <= '0;
      end else begin
         for (int unsigned n = 0; n < 3; n++) begin
            state_q[n] <= state_d[n];
            if (load[n])
               data_q[n] <= in_data;
         end
         if (drop && drop_count != '1)
            drop_count <= drop_count + 1'b1;
      end
   end

   assign out0_data  = data_q[0];
   assign out1_data  = data_q[1];
   assign out2_data  = data_q[2];
   assign out0_valid = (state_q[0] == FULL);
   assign out1_valid = (state_q[1] == FULL);
   assign out2_valid = (state_q[2] == FULL);

endmodule

// File: tb/tb_demux3_buf.sv
// Directed self-checking bench for demux3_buf.
module tb_demux3_buf;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_data;
   logic [1:0]  in_select;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out0_data, out1_data, out2_data;
   logic        out0_valid, out1_valid, out2_valid;
   logic        out0_ack, out1_ack, out2_ack;
   logic [7:0]  drop_count;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   demux3_buf #(.WIDTH(16), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_select(in_select), .in_valid(in_valid), .in_ready(in_ready),
      .out0_data(out0_data), .out0_valid(out0_valid), .out0_ack(out0_ack),
      .out1_data(out1_data), .out1_valid(out1_valid), .out1_ack(out1_ack),
      .out2_data(out2_data), .out2_valid(out2_valid), .out2_ack(out2_ack),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and registers are sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      out0_ack = 1'b0;
      out1_ack = 1'b0;
      out2_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_data = '0; in_select = '0;
      idle();
      #1;
      check("ready_in_reset", in_ready, 0);
      tick();
      check("rst_v0", out0_valid, 0);
      check("rst_v1", out1_valid, 0);
      check("rst_v2", out2_valid, 0);
      check("rst_drop", drop_count, 0);
      reset = 1'b0;

      // single transfer to out1
      in_data = 16'h1234; in_select = 2'd1; in_valid = 1'b1;
      #1 check("t1_ready", in_ready, 1);
      tick(); idle();
      check("t1_v1", out1_valid, 1);
      check("t1_d1", out1_data, 16'h1234);
      check("t1_v0", out0_valid, 0);
      check("t1_v2", out2_valid, 0);

      // back-pressure on full out1, released by ack (refill)
      in_data = 16'hBEEF; in_select = 2'd1; in_valid = 1'b1;
      #1 check("t2_stall_ready", in_ready, 0);
      tick();
      check("t2_hold_d1", out1_data, 16'h1234);
      check("t2_hold_v1", out1_valid, 1);
      out1_ack = 1'b1;
      #1 check("t2_ack_ready", in_ready, 1);
      tick(); idle();
      check("t2_refill_d1", out1_data, 16'hBEEF);
      check("t2_refill_v1", out1_valid, 1);
      out1_ack = 1'b1;
      tick(); idle();
      check("t2_drain_v1", out1_valid, 0);

      // streaming to out0 with continuous ack
      out0_ack = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_data = 16'(i); in_select = 2'd0; in_valid = 1'b1;
         #1 check("t3_ready", in_ready, 1);
         tick();
         check("t3_d0", out0_data, 32'(i));
         check("t3_v0", out0_valid, 1);
      end
      in_valid = 1'b0;
      tick(); idle();
      check("t3_drain_v0", out0_valid, 0);

      // stalled out2 does not block out0
      in_data = 16'h5555; in_select = 2'd2; in_valid = 1'b1;
      tick(); idle();
      check("t4_v2", out2_valid, 1);
      in_select = 2'd2; in_data = 16'h7777;
      #1 check("t4_v2_stalled_ready", in_ready, 0);
      in_data = 16'hAAAA; in_select = 2'd0; in_valid = 1'b1;
      #1 check("t4_ready0", in_ready, 1);
      tick(); idle();
      check("t4_d0", out0_data, 16'hAAAA);
      check("t4_d2", out2_data, 16'h5555);
      check("t4_v2_held", out2_valid, 1);

      // simultaneous independent acks empty both channels
      out0_ack = 1'b1; out2_ack = 1'b1;
      tick(); idle();
      check("t4b_v0", out0_valid, 0);
      check("t4b_v2", out2_valid, 0);

      // drop counter saturation
      in_select = 2'd3; in_data = 16'hDEAD; in_valid = 1'b1;
      #1 check("t5_ready", in_ready, 1);
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (i == 5)   check("t5_drop5", drop_count, 5);
         if (i == 254) check("t5_drop254", drop_count, 254);
         if (i == 255) check("t5_drop255", drop_count, 255);
      end
      idle();
      check("t5_drop_sat", drop_count, 255);
      check("t5_v0", out0_valid, 0);
      check("t5_v1", out1_valid, 0);
      check("t5_v2", out2_valid, 0);

      // reset with all channels full and a pending transfer
      reset = 1'b1; tick(); reset = 1'b0;
      check("t6_pre_drop", drop_count, 0);
      for (int c = 0; c < 3; c++) begin
         in_data = 16'hC000 + 16'(c); in_select = 2'(c); in_valid = 1'b1;
         tick();
      end
      in_select = 2'd3; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      idle();
      check("t6_d2_full", out2_data, 16'hC002);
      check("t6_v1_full", out1_valid, 1);
      check("t6_drop5", drop_count, 5);
      reset = 1'b1; in_valid = 1'b1; in_select = 2'd3; out0_ack = 1'b1;
      #1 check("t6_ready_rst", in_ready, 0);
      tick();
      reset = 1'b0; idle();
      check("t6_v0", out0_valid, 0);
      check("t6_v1", out1_valid, 0);
      check("t6_v2", out2_valid, 0);
      check("t6_d0", out0_data, 0);
      check("t6_d1", out1_data, 0);
      check("t6_d2", out2_data, 0);
      check("t6_drop", drop_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
